// File: rtl/demux1x16_deser.sv
// 1:N_CH time-division demultiplexer: rebuilds a parallel word from a serial lane-ordered stream.
// Optional lane strobe output is enabled by defining DEMUX_LANE_STROBE_EN.
module demux1x16_deser #(
  parameter int N_CH = 16,
  parameter int CW   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_bit,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic [CW-1:0]   cur_ch,
  output logic [N_CH-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
`ifdef DEMUX_LANE_STROBE_EN
  ,
  output logic [N_CH-1:0] lane_en
`endif
);

  typedef enum logic {FILL, STALL} state_t;

  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [N_CH-1:0]   r_asm, w_asm_nxt;
  logic [N_CH-1:0]   r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              w_load;

  // in_ready depends only on the state register, so out_ready never reaches it combinationally.
  assign in_ready  = (r_state == FILL);
  assign cur_ch    = r_cnt;
  assign out_data  = r_data;
  assign out_valid = r_valid;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_asm_nxt   = r_asm;
    w_data_nxt  = r_data;
    w_load      = 1'b0;

    if (flush) begin
      w_cnt_nxt   = '0;
      w_asm_nxt   = '0;
      w_state_nxt = FILL;
    end else if (r_state == STALL) begin
      if (out_ready) begin
        w_data_nxt  = r_asm;
        w_load      = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = FILL;
      end
    end else if (in_valid) begin
      w_asm_nxt[r_cnt] = in_bit;
      if (r_cnt != LAST_CH) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end else if (!r_valid || out_ready) begin
        w_data_nxt = {in_bit, r_asm[N_CH-2:0]};
        w_load     = 1'b1;
        w_cnt_nxt  = '0;
      end else begin
        w_state_nxt = STALL;
      end
    end

    // A consumed word stays valid only if a new one replaces it in the same cycle.
    w_valid_nxt = w_load | (r_valid & ~out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_asm   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_asm   <= w_asm_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

`ifdef DEMUX_LANE_STROBE_EN
  logic [N_CH-1:0] r_lane_en;
  logic            w_beat;

  assign w_beat  = in_valid && !flush && (r_state == FILL);
  assign lane_en = r_lane_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_en <= '0;
    end else begin
      r_lane_en <= w_beat ? (N_CH'(1) << r_cnt) : '0;
    end
  end
`endif

endmodule

// File: tb/tb_demux1x16_deser.sv
// Self-checking bench for demux1x16_deser: directed scenarios plus random traffic against a
// frame/buffer-level reference model. Define DEMUX_LANE_STROBE_EN to also check lane_en.
module tb_demux1x16_deser;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_bit, in_valid, flush, out_ready;
  logic          in_ready, out_valid;
  logic [3:0]    cur_ch;
  logic [N-1:0]  out_data;
`ifdef DEMUX_LANE_STROBE_EN
  logic [N-1:0]  lane_en;
`endif

  int total = 0;
  int bad   = 0;

  demux1x16_deser #(.N_CH(N), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .cur_ch    (cur_ch),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_LANE_STROBE_EN
    ,
    .lane_en   (lane_en)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: bits collected so far, a one-word output buffer, and one pending full frame.
  logic [N-1:0] m_frm, m_out, m_pend, m_lane;
  int           m_n;
  bit           m_out_v, m_pend_v;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_frm = '0; m_out = '0; m_pend = '0; m_lane = '0;
    m_n = 0; m_out_v = 0; m_pend_v = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit fl, input bit ordy);
    bit loaded;
    bit pop;
    loaded = 0;
    pop    = m_out_v && ordy;
    m_lane = '0;
    if (fl) begin
      m_n = 0; m_frm = '0; m_pend_v = 0;
    end else if (m_pend_v) begin
      if (ordy) begin
        m_out = m_pend; loaded = 1; m_pend_v = 0; m_n = 0;
      end
    end else if (v) begin
      m_frm[m_n] = b;
      m_lane     = N'(1) << m_n;
      if (m_n < N - 1) m_n++;
      else if (!m_out_v || ordy) begin
        m_out = m_frm; loaded = 1; m_n = 0;
      end else begin
        m_pend = m_frm; m_pend_v = 1;
      end
    end
    if (loaded) m_out_v = 1;
    else if (pop) m_out_v = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_cur_ch"},   32'(cur_ch),    32'(m_n));
    check({tag, "_in_ready"}, 32'(in_ready),  32'(!m_pend_v));
    check({tag, "_out_data"}, 32'(out_data),  32'(m_out));
    check({tag, "_out_valid"},32'(out_valid), 32'(m_out_v));
`ifdef DEMUX_LANE_STROBE_EN
    check({tag, "_lane_en"},  32'(lane_en),   32'(m_lane));
`endif
  endtask

  task automatic step(input bit v, input bit b, input bit fl, input bit ordy, input string tag);
    in_valid  = v;
    in_bit    = b;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
    model_step(v, b, fl, ordy);
    check_model(tag);
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit ordy, input string tag);
    for (int i = 0; i < N; i++) step(1'b1, w[i], 1'b0, ordy, tag);
  endtask

  task automatic pulse_reset(input string tag);
    in_valid = 0; in_bit = 0; flush = 0; out_ready = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] w1, w2, w3;
    in_valid = 0; in_bit = 0; flush = 0; out_ready = 0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_cur_ch", 32'(cur_ch), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Alternating pattern with the consumer always ready.
    for (int i = 0; i < N; i++) begin
      step(1'b1, (i % 2 == 0), 1'b0, 1'b1, "pat");
`ifdef DEMUX_LANE_STROBE_EN
      check("pat_lane_walk", 32'(lane_en), 32'(1) << i);
`endif
    end
    check("pat_word", 32'(out_data), 32'h5555);
    check("pat_valid", 32'(out_valid), 32'h1);
    check("pat_cur_ch_wrap", 32'(cur_ch), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, "pat_drain");
`ifdef DEMUX_LANE_STROBE_EN
    check("pat_lane_idle", 32'(lane_en), 32'h0);
`endif

    // Backpressure: two frames with the consumer stalled.
    send_word(16'hA5C3, 1'b0, "bp1");
    check("bp1_word", 32'(out_data), 32'hA5C3);
    send_word(16'h0F0F, 1'b0, "bp2");
    check("bp_stall_in_ready", 32'(in_ready), 32'h0);
    check("bp_stall_held", 32'(out_data), 32'hA5C3);
    check("bp_stall_cur_ch", 32'(cur_ch), 32'hF);
    step(1'b1, 1'b1, 1'b0, 1'b0, "bp_ignored_beat");
    step(1'b0, 1'b0, 1'b0, 1'b1, "bp_release");
    check("bp_release_word", 32'(out_data), 32'h0F0F);
    check("bp_release_in_ready", 32'(in_ready), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, "bp_drain");

    // Consumer frees the buffer on the very beat that completes frame 2.
    w1 = N'($urandom);
    w2 = N'($urandom);
    send_word(w1, 1'b0, "sim1");
    for (int i = 0; i < N - 1; i++) step(1'b1, w2[i], 1'b0, 1'b0, "sim2");
    step(1'b1, w2[N-1], 1'b0, 1'b1, "sim_last");
    check("sim_in_ready", 32'(in_ready), 32'h1);
    check("sim_word", 32'(out_data), 32'(w2));
    step(1'b0, 1'b0, 1'b0, 1'b1, "sim_drain");

    // Flush mid-frame: the beat presented with flush is ignored.
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'b0, 1'b1, "fl_part");
    step(1'b1, 1'b1, 1'b1, 1'b1, "fl_pulse");
    check("fl_cur_ch", 32'(cur_ch), 32'h0);
    w3 = N'($urandom);
    send_word(w3, 1'b1, "fl_clean");
    check("fl_clean_word", 32'(out_data), 32'(w3));

    // Reset mid-frame with a buffered word present.
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, "rst_part");
    pulse_reset("rst_mid");

    // Flush while stalled discards the pending frame but keeps the buffered word.
    send_word(16'h1234, 1'b0, "fs1");
    send_word(16'hBEEF, 1'b0, "fs2");
    step(1'b0, 1'b0, 1'b1, 1'b0, "fs_flush");
    check("fs_in_ready", 32'(in_ready), 32'h1);
    check("fs_word_kept", 32'(out_data), 32'h1234);
    check("fs_valid_kept", 32'(out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, "fs_drain");

    // Random traffic with gaps, backpressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, 1'($urandom), ($urandom % 40) == 0, ($urandom % 3) != 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
